// File: rtl/undistort_bram_writer.sv
// undistort_bram_writer: final stage of the undistort datapath.
// Accepts interpolated pixels tagged with destination (u,v), writes them to the
// output frame BRAM at v*COLS+u, counts them, and reports/holds a finished frame
// until the host transfer completes.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               one-cycle arm pulse from the control FSM
//   pix_valid/pix_ready pixel handshake; pix_data, pix_u, pix_v are the payload
//   transfer_done       host readout of the output frame complete
//   bram_we/addr/din    output BRAM write port (1-cycle latency after accept)
//   processed_pixels    pixels written this frame
//   bram_writer_done    one-cycle pulse on frame completion
//   frame_ready         frame complete, held until transfer_done
//   busy                high in any state except IDLE
//
// Optional feature macro: UNDISTORT_WRITER_BOUNDS_CHECK_EN
//   Adds oob_count[15:0]; out-of-range pixels are consumed but neither written
//   nor counted as processed, and instead bump the saturating oob_count.
module undistort_bram_writer #(
    parameter int unsigned ROWS    = 240,
    parameter int unsigned COLS    = 320,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COORD_W = 9,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [DATA_W-1:0]   pix_data,
    input  logic [COORD_W-1:0]  pix_u,
    input  logic [COORD_W-1:0]  pix_v,
    input  logic                transfer_done,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    output logic [ADDR_W-1:0]   processed_pixels,
    output logic                bram_writer_done,
    output logic                frame_ready,
    output logic                busy
`ifdef UNDISTORT_WRITER_BOUNDS_CHECK_EN
    ,
    output logic [15:0]         oob_count
`endif
);

    localparam int unsigned     FRAME_PIX = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                pix_ready_q, pix_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                frame_ready_q, frame_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                accept_c;
    logic                write_c;
    logic [ADDR_W-1:0]   addr_c;

    // pix_ready_q is high exactly while in WRITE, so this is the handshake
    assign accept_c = pix_valid & pix_ready_q;
    assign addr_c   = ADDR_W'(pix_v) * COLS_A + ADDR_W'(pix_u);

`ifdef UNDISTORT_WRITER_BOUNDS_CHECK_EN
    logic        in_range_c;
    logic [15:0] oob_q, oob_d;

    assign in_range_c = (32'(pix_u) < COLS) && (32'(pix_v) < ROWS);
    assign write_c    = accept_c & in_range_c;

    // Out-of-range counter: cleared on arm, saturates at all-ones
    always_comb begin
        oob_d = oob_q;
        if (state_q == S_IDLE && start) begin
            oob_d = '0;
        end else if (accept_c && !in_range_c && oob_q != 16'hFFFF) begin
            oob_d = oob_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) oob_q <= '0;
        else      oob_q <= oob_d;
    end

    assign oob_count = oob_q;
`else
    assign write_c = accept_c;
`endif

    // State register and registered datapath/outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pix_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pix_ready_q   <= pix_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_ready_q <= frame_ready_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state logic; completion is purely count-based
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WRITE;
            S_WRITE: if (write_c && cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE:  state_d = S_HOLD;
            S_HOLD:  if (transfer_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write port and pixel counter
    always_comb begin
        we_d   = write_c;
        addr_d = addr_q;
        din_d  = din_q;
        cnt_d  = cnt_q;
        if (write_c) begin
            addr_d = addr_c;
            din_d  = pix_data;
            cnt_d  = cnt_q + ADDR_W'(1);
        end
        if (state_q == S_IDLE && start) begin
            cnt_d = '0;
        end
    end

    // Control outputs decoded from the upcoming state so they register cleanly
    always_comb begin
        pix_ready_d   = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        frame_ready_d = 1'b0;
        case (state_d)
            S_IDLE:  ;
            S_WRITE: begin
                pix_ready_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            S_HOLD: begin
                frame_ready_d = 1'b1;
                busy_d        = 1'b1;
            end
            default: ;
        endcase
    end

    assign pix_ready        = pix_ready_q;
    assign busy             = busy_q;
    assign bram_writer_done = done_q;
    assign frame_ready      = frame_ready_q;
    assign bram_we          = we_q;
    assign bram_addr        = addr_q;
    assign bram_din         = din_q;
    assign processed_pixels = cnt_q;

endmodule

// File: tb/tb_undistort_bram_writer.sv
// Testbench for undistort_bram_writer. COLS stays at 320 so the addressing
// vectors are the real ones; ROWS is reduced to 6 to keep the full-frame run short.
module tb_undistort_bram_writer;

    localparam int unsigned ROWS  = 6;
    localparam int unsigned COLS  = 320;
    localparam int unsigned FRAME = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [8:0]  pix_u;
    logic [8:0]  pix_v;
    logic        transfer_done;
    logic        bram_we;
    logic [16:0] bram_addr;
    logic [7:0]  bram_din;
    logic [16:0] processed_pixels;
    logic        bram_writer_done;
    logic        frame_ready;
    logic        busy;
`ifdef UNDISTORT_WRITER_BOUNDS_CHECK_EN
    logic [15:0] oob_count;
`endif

    undistort_bram_writer #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(8), .COORD_W(9), .ADDR_W(17)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_u(pix_u), .pix_v(pix_v), .transfer_done(transfer_done),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .processed_pixels(processed_pixels), .bram_writer_done(bram_writer_done),
        .frame_ready(frame_ready), .busy(busy)
`ifdef UNDISTORT_WRITER_BOUNDS_CHECK_EN
        , .oob_count(oob_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic        pv;
        logic [8:0]  u;
        logic [8:0]  v;
        logic [7:0]  d;
        logic        we;
        logic [16:0] addr;
        logic [7:0]  din;
        logic [16:0] cnt;
        logic        rdy;
        logic        bsy;
    } vec_t;

    vec_t tbl[8];

    function automatic vec_t mk(logic s, logic pv, int u, int v, logic [7:0] d,
                                logic we, int addr, logic [7:0] din, int cnt,
                                logic rdy, logic bsy);
        vec_t r;
        r.start = s;  r.pv = pv; r.u = 9'(u); r.v = 9'(v); r.d = d;
        r.we = we; r.addr = 17'(addr); r.din = din; r.cnt = 17'(cnt);
        r.rdy = rdy; r.bsy = bsy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Drive inputs for one cycle, then step past the edge for sampling
    task automatic cyc(input logic s, input logic pv, input int u, input int v,
                       input logic [7:0] d, input logic td);
        start = s; pix_valid = pv; pix_u = 9'(u); pix_v = 9'(v);
        pix_data = d; transfer_done = td;
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;
    int writes;
    int done_seen;
    int last_addr;
    int p;
    int budget;
    logic pv;
    logic acc;

    initial begin
        rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        pix_u = '0; pix_v = '0; transfer_done = 1'b0;

        tbl[0] = mk(0, 1,   0, 0, 8'h00, 0,    0, 8'h00, 0, 0, 0); // valid without start
        tbl[1] = mk(1, 0,   0, 0, 8'h00, 0,    0, 8'h00, 0, 1, 1); // arm
        tbl[2] = mk(0, 1,   5, 2, 8'hA7, 1,  645, 8'hA7, 1, 1, 1);
        tbl[3] = mk(0, 1,   0, 0, 8'h11, 1,    0, 8'h11, 2, 1, 1);
        tbl[4] = mk(0, 0,   0, 0, 8'h00, 0,    0, 8'h00, 2, 1, 1); // gap
        tbl[5] = mk(0, 1, 319, 5, 8'h3C, 1, 1919, 8'h3C, 3, 1, 1);
        tbl[6] = mk(0, 1,   5, 2, 8'h55, 1,  645, 8'h55, 4, 1, 1); // duplicate still counted
        tbl[7] = mk(1, 0,   0, 0, 8'h00, 0,    0, 8'h00, 4, 1, 1); // start ignored in WRITE

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(pix_ready), 0);
        chk("rst_we",    32'(bram_we), 0);
        chk("rst_addr",  32'(bram_addr), 0);
        chk("rst_din",   32'(bram_din), 0);
        chk("rst_cnt",   32'(processed_pixels), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(bram_writer_done), 0);
        chk("rst_frdy",  32'(frame_ready), 0);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].start, tbl[i].pv, int'(tbl[i].u), int'(tbl[i].v), tbl[i].d, 1'b0);
            chk($sformatf("vec%0d_we", i),    32'(bram_we), 32'(tbl[i].we));
            chk($sformatf("vec%0d_cnt", i),   32'(processed_pixels), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_ready", i), 32'(pix_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_busy", i),  32'(busy), 32'(tbl[i].bsy));
            if (tbl[i].we) begin
                chk($sformatf("vec%0d_addr", i), 32'(bram_addr), 32'(tbl[i].addr));
                chk($sformatf("vec%0d_din", i),  32'(bram_din), 32'(tbl[i].din));
            end
        end

        // Rest of the frame in raster order with random valid gaps
        exp_cnt = 4; writes = 4; done_seen = 0; last_addr = -1; p = 4; budget = 20000;
        while (budget > 0 && done_seen == 0) begin
            budget--;
            pv  = (p < int'(FRAME)) ? ($urandom_range(0, 3) != 0) : 1'b1;
            acc = pv && (exp_cnt < int'(FRAME));
            cyc(1'b0, pv, p % int'(COLS), p / int'(COLS), 8'(p * 7), 1'b0);
            if (bram_we !== acc) chk("stream_we", 32'(bram_we), 32'(acc));
            if (acc) begin
                if (bram_addr !== 17'(p)) chk("stream_addr", 32'(bram_addr), 32'(p));
                if (bram_din !== 8'(p * 7)) chk("stream_din", 32'(bram_din), 32'(8'(p * 7)));
                last_addr = int'(bram_addr);
                exp_cnt++; writes++; p++;
            end
            if (bram_writer_done) done_seen++;
            if (bram_writer_done !== (acc && exp_cnt == int'(FRAME)))
                chk("stream_done_timing", 32'(bram_writer_done), 32'(acc && exp_cnt == int'(FRAME)));
        end
        chk("frame_done_seen", 32'(done_seen), 1);
        chk("frame_writes", 32'(writes), FRAME);
        chk("frame_last_addr", 32'(last_addr), FRAME - 1);
        chk("frame_cnt", 32'(processed_pixels), FRAME);

        // Valid held after the last accept, plus a start pulse in HOLD
        for (int i = 0; i < 3; i++) begin
            cyc(i == 1, 1'b1, 0, 0, 8'hEE, 1'b0);
            chk("hold_ready", 32'(pix_ready), 0);
            chk("hold_we",    32'(bram_we), 0);
            chk("hold_done",  32'(bram_writer_done), 0);
            chk("hold_frdy",  32'(frame_ready), 1);
            chk("hold_busy",  32'(busy), 1);
            chk("hold_cnt",   32'(processed_pixels), FRAME);
        end

        // start and transfer_done together in HOLD: transfer_done wins
        cyc(1'b1, 1'b0, 0, 0, 8'h00, 1'b1);
        chk("both_frdy",  32'(frame_ready), 0);
        chk("both_busy",  32'(busy), 0);
        chk("both_ready", 32'(pix_ready), 0);
        cyc(1'b0, 1'b1, 0, 0, 8'h00, 1'b0);
        chk("idle_ready", 32'(pix_ready), 0);
        chk("idle_we",    32'(bram_we), 0);
        cyc(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
        chk("rearm_ready", 32'(pix_ready), 1);
        chk("rearm_cnt",   32'(processed_pixels), 0);

        // Reset mid-frame after 1000 pixels
        done_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b0, 1'b1, i % int'(COLS), i / int'(COLS), 8'(i), 1'b0);
            if (bram_writer_done) done_seen++;
        end
        chk("mid_cnt", 32'(processed_pixels), 1000);
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt",   32'(processed_pixels), 0);
        chk("mid_rst_we",    32'(bram_we), 0);
        chk("mid_rst_ready", 32'(pix_ready), 0);
        chk("mid_rst_busy",  32'(busy), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bram_writer_done) done_seen++;
        end
        chk("mid_rst_no_done", 32'(done_seen), 0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1, 0, 8'h01, 1'b0);
        chk("post_rst_ready", 32'(pix_ready), 0);
        chk("post_rst_we",    32'(bram_we), 0);

        // Out-of-range column
        cyc(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 320, 0, 8'h99, 1'b0);
`ifdef UNDISTORT_WRITER_BOUNDS_CHECK_EN
        chk("oob_we",    32'(bram_we), 0);
        chk("oob_count", 32'(oob_count), 1);
        chk("oob_cnt",   32'(processed_pixels), 0);
`else
        chk("oob_we",    32'(bram_we), 1);
        chk("oob_addr",  32'(bram_addr), 320);
        chk("oob_cnt",   32'(processed_pixels), 1);
`endif
        pix_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
